// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg: shared FSM encoding and index-width helper for the RAM arbiter.
package mem_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; searches upward from i_ptr with wrap,
// ignoring any requester whose mask bit is set.
module rr_pick
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NREQ = 8,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_mask,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);

    logic [NREQ-1:0] w_req;

    assign w_req   = i_req & ~i_mask;
    assign o_valid = |w_req;

    // Scan from farthest to nearest so the candidate closest to the pointer wins.
    always_comb begin
        o_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (w_req[IW'(int'(i_ptr) + k)]) o_idx = IW'(int'(i_ptr) + k);
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter sharing one single-port synchronous RAM between
// NREQ requesters, one access in flight, with a registered read-data slot per requester.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NREQ   = 8,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      rden,
    input  logic [NREQ-1:0]      wren,
    input  logic [NREQ*AW-1:0]   Address,
    input  logic [NREQ*DW-1:0]   Din,
    output logic [NREQ-1:0]      acq,
    output logic [NREQ*DW-1:0]   Dq,
    output logic [AW-1:0]        RAMAddress,
    output logic [DW-1:0]        RAMDin,
    output logic                 RAMwren,
    input  logic [DW-1:0]        RAMq,
    output logic                 busy
);

    localparam int IW = clog2(NREQ);

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_grant;
    logic [IW-1:0]      r_rr;
    logic [1:0]         r_cnt;
    logic [AW-1:0]      r_ram_addr;
    logic [DW-1:0]      r_ram_din;
    logic               r_ram_wren;
    logic [NREQ*DW-1:0] r_dq;
    logic               w_valid;
    logic               w_take;
    logic [IW-1:0]      w_pick;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req   (rden | wren),
        .i_mask  (acq),
        .i_ptr   (r_rr),
        .o_valid (w_valid),
        .o_idx   (w_pick)
    );

    // acq doubles as the arbitration mask: only the finishing requester is excluded.
    assign acq        = (r_state == DONE) ? NREQ'(1) << r_grant : '0;
    assign busy       = r_state != IDLE;
    assign w_take     = w_valid && (r_state == IDLE || r_state == DONE);
    assign Dq         = r_dq;
    assign RAMAddress = r_ram_addr;
    assign RAMDin     = r_ram_din;
    assign RAMwren    = r_ram_wren;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = ACCESS;
            ACCESS:  w_next = r_ram_wren ? DONE : WAIT;
            WAIT:    if (r_cnt == 2'd0) w_next = DONE;
            default: w_next = w_valid ? ACCESS : IDLE;
        endcase
    end

    // The RAM port registers are the latched request, so ACCESS sees them at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr       <= '0;
            r_cnt      <= '0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_wren <= 1'b0;
            r_dq       <= '0;
        end else begin
            r_state    <= w_next;
            r_ram_wren <= 1'b0;
            if (w_take) begin
                r_grant    <= w_pick;
                r_rr       <= w_pick + IW'(1);
                r_ram_addr <= Address[int'(w_pick)*AW +: AW];
                r_ram_din  <= Din[int'(w_pick)*DW +: DW];
                r_ram_wren <= wren[w_pick];
            end
            if (r_state == ACCESS) r_cnt <= 2'(RD_LAT - 1);
            else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 2'd1;
                if (r_cnt == 2'd0) r_dq[int'(r_grant)*DW +: DW] <= RAMq;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed bench for mem_arbiter_rr with RD_LAT=1 and RD_LAT=2 instances,
// each backed by its own behavioural synchronous RAM.
module tb_mem_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rden = '0, wren = '0;
    logic [63:0] addr_bus = '0, din_bus = '0;
    logic [7:0]  acq1, ra1, rd1, rq1, acq2, ra2, rd2, rq2, p2;
    logic        rw1, rw2, busy1, busy2;
    logic [63:0] dq1, dq2;
    logic [7:0]  mem1 [256];
    logic [7:0]  mem2 [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_a = '0, pl_d = '0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(.NREQ(8), .AW(8), .DW(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .rden(rden), .wren(wren), .Address(addr_bus), .Din(din_bus),
        .acq(acq1), .Dq(dq1), .RAMAddress(ra1), .RAMDin(rd1), .RAMwren(rw1), .RAMq(rq1), .busy(busy1)
    );

    mem_arbiter_rr #(.NREQ(8), .AW(8), .DW(8), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .rden(rden), .wren(wren), .Address(addr_bus), .Din(din_bus),
        .acq(acq2), .Dq(dq2), .RAMAddress(ra2), .RAMDin(rd2), .RAMwren(rw2), .RAMq(rq2), .busy(busy2)
    );

    always @(posedge clk) begin
        if (pl_en) mem1[pl_a] <= pl_d;
        else if (rw1) mem1[ra1] <= rd1;
        rq1 <= mem1[ra1];
    end

    always @(posedge clk) begin
        if (pl_en) mem2[pl_a] <= pl_d;
        else if (rw2) mem2[ra2] <= rd2;
        p2  <= mem2[ra2];
        rq2 <= p2;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_a = a; pl_d = d; pl_en = 1'b1;
        tick;
        pl_en = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] d);
        addr_bus[i*8 +: 8] = a;
        din_bus[i*8 +: 8]  = d;
    endtask

    task automatic do_reset;
        rst = 1'b0; rden = '0; wren = '0;
        tick; tick;
        rst = 1'b1;
    endtask

    function automatic logic [7:0] slot(input logic [63:0] v, input int i);
        return v[i*8 +: 8];
    endfunction

    task automatic test_reset;
        rst = 1'b0;
        preload(8'h10, 8'hA5);
        preload(8'h30, 8'h99);
        for (int i = 0; i < 8; i++) preload(8'(8'h40 + i), 8'(8'hC0 + i));
        preload(8'h50, 8'hD0);
        preload(8'h51, 8'hD1);
        preload(8'h60, 8'h5A);
        preload(8'h61, 8'h6B);
        preload(8'h70, 8'hE7);
        checks++; if (acq1 !== 8'h00) begin failures++; $display("FAIL rst_acq got=%h exp=00", acq1); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy1); end
        checks++; if (rw1 !== 1'b0) begin failures++; $display("FAIL rst_wren got=%b exp=0", rw1); end
        checks++; if (ra1 !== 8'h00 || rd1 !== 8'h00) begin failures++; $display("FAIL rst_ramport got=%h/%h exp=00/00", ra1, rd1); end
        checks++; if (dq1 !== 64'h0) begin failures++; $display("FAIL rst_dq got=%h exp=0", dq1); end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_single_read;
        set_req(3, 8'h10, 8'h00);
        rden[3] = 1'b1;
        tick;
        checks++; if (ra1 !== 8'h10) begin failures++; $display("FAIL rd_addr got=%h exp=10", ra1); end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL rd_busy got=%b exp=1", busy1); end
        tick;
        checks++; if (acq1 !== 8'h00) begin failures++; $display("FAIL rd_early_acq got=%h exp=00", acq1); end
        tick;
        checks++; if (acq1 !== 8'h08) begin failures++; $display("FAIL rd_acq got=%h exp=08", acq1); end
        checks++; if (dq1 !== 64'h0000_0000_A500_0000) begin failures++; $display("FAIL rd_dq got=%h exp=00000000a5000000", dq1); end
        rden[3] = 1'b0;
        tick;
        checks++; if (busy1 !== 1'b0 || acq1 !== 8'h00) begin failures++; $display("FAIL rd_idle got=%b/%h exp=0/00", busy1, acq1); end
    endtask

    task automatic test_single_write;
        set_req(5, 8'h22, 8'h3C);
        wren[5] = 1'b1;
        tick;
        checks++; if (rw1 !== 1'b1 || ra1 !== 8'h22 || rd1 !== 8'h3C) begin failures++; $display("FAIL wr_port got=%b/%h/%h exp=1/22/3c", rw1, ra1, rd1); end
        checks++; if (acq1 !== 8'h00) begin failures++; $display("FAIL wr_early_acq got=%h exp=00", acq1); end
        tick;
        checks++; if (acq1 !== 8'h20 || rw1 !== 1'b0) begin failures++; $display("FAIL wr_acq got=%h/%b exp=20/0", acq1, rw1); end
        wren[5] = 1'b0;
        tick;
        checks++; if (mem1[8'h22] !== 8'h3C) begin failures++; $display("FAIL wr_ram got=%h exp=3c", mem1[8'h22]); end
        set_req(0, 8'h22, 8'h00);
        rden[0] = 1'b1;
        tick; tick; tick;
        checks++; if (acq1 !== 8'h01) begin failures++; $display("FAIL wr_rdback_acq got=%h exp=01", acq1); end
        checks++; if (dq1 !== 64'h0000_0000_A500_003C) begin failures++; $display("FAIL wr_rdback_dq got=%h exp=00000000a500003c", dq1); end
        rden[0] = 1'b0;
        tick;
    endtask

    task automatic test_read_write_both;
        set_req(1, 8'h30, 8'h77);
        rden[1] = 1'b1; wren[1] = 1'b1;
        tick;
        checks++; if (rw1 !== 1'b1 || ra1 !== 8'h30 || rd1 !== 8'h77) begin failures++; $display("FAIL both_port got=%b/%h/%h exp=1/30/77", rw1, ra1, rd1); end
        tick;
        checks++; if (acq1 !== 8'h02) begin failures++; $display("FAIL both_acq got=%h exp=02", acq1); end
        rden[1] = 1'b0; wren[1] = 1'b0;
        tick;
        checks++; if (acq1 !== 8'h00 || busy1 !== 1'b0) begin failures++; $display("FAIL both_single got=%h/%b exp=00/0", acq1, busy1); end
        checks++; if (slot(dq1, 1) !== 8'h00) begin failures++; $display("FAIL both_dq got=%h exp=00", slot(dq1, 1)); end
        checks++; if (mem1[8'h30] !== 8'h77) begin failures++; $display("FAIL both_ram got=%h exp=77", mem1[8'h30]); end
    endtask

    task automatic test_contention;
        do_reset;
        for (int i = 0; i < 8; i++) set_req(i, 8'(8'h40 + i), 8'h00);
        rden = 8'hFF;
        tick;
        checks++; if (busy1 !== 1'b1 || acq1 !== 8'h00) begin failures++; $display("FAIL cont_start got=%b/%h exp=1/00", busy1, acq1); end
        for (int k = 0; k < 8; k++) begin
            tick;
            checks++; if (busy1 !== 1'b1 || acq1 !== 8'h00) begin failures++; $display("FAIL cont_wait k=%0d got=%b/%h exp=1/00", k, busy1, acq1); end
            tick;
            checks++; if (acq1 !== 8'(1 << k)) begin failures++; $display("FAIL cont_acq k=%0d got=%h exp=%h", k, acq1, 8'(1 << k)); end
            checks++; if (slot(dq1, k) !== 8'(8'hC0 + k)) begin failures++; $display("FAIL cont_dq k=%0d got=%h exp=%h", k, slot(dq1, k), 8'(8'hC0 + k)); end
            rden[k] = 1'b0;
            if (k < 7) begin
                tick;
                checks++; if (busy1 !== 1'b1 || ra1 !== 8'(8'h41 + k)) begin failures++; $display("FAIL cont_access k=%0d got=%b/%h exp=1/%h", k, busy1, ra1, 8'(8'h41 + k)); end
            end
        end
        tick;
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL cont_idle got=%b exp=0", busy1); end
    endtask

    task automatic test_starvation;
        do_reset;
        set_req(2, 8'h50, 8'h00);
        rden[2] = 1'b1;
        tick;
        set_req(6, 8'h51, 8'h00);
        rden[6] = 1'b1;
        tick; tick;
        checks++; if (acq1 !== 8'h04 || slot(dq1, 2) !== 8'hD0) begin failures++; $display("FAIL starv_first got=%h/%h exp=04/d0", acq1, slot(dq1, 2)); end
        tick;
        checks++; if (busy1 !== 1'b1 || ra1 !== 8'h51) begin failures++; $display("FAIL starv_next got=%b/%h exp=1/51", busy1, ra1); end
        tick; tick;
        checks++; if (acq1 !== 8'h40 || slot(dq1, 6) !== 8'hD1) begin failures++; $display("FAIL starv_six got=%h/%h exp=40/d1", acq1, slot(dq1, 6)); end
        rden[6] = 1'b0;
        tick; tick; tick;
        checks++; if (acq1 !== 8'h04) begin failures++; $display("FAIL starv_two got=%h exp=04", acq1); end
        rden[2] = 1'b0;
        tick;
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL starv_idle got=%b exp=0", busy1); end
    endtask

    task automatic test_reset_mid_access;
        set_req(4, 8'h60, 8'h00);
        rden[4] = 1'b1;
        tick; tick;
        set_req(7, 8'h61, 8'h00);
        rden[7] = 1'b1;
        rst = 1'b0;
        #2;
        checks++; if (acq1 !== 8'h00 || rw1 !== 1'b0) begin failures++; $display("FAIL mid_rst_port got=%h/%b exp=00/0", acq1, rw1); end
        checks++; if (dq1 !== 64'h0 || busy1 !== 1'b0) begin failures++; $display("FAIL mid_rst_state got=%h/%b exp=0/0", dq1, busy1); end
        tick;
        rst = 1'b1;
        tick;
        checks++; if (ra1 !== 8'h60) begin failures++; $display("FAIL mid_ptr0 got=%h exp=60", ra1); end
        tick; tick;
        checks++; if (acq1 !== 8'h10 || slot(dq1, 4) !== 8'h5A) begin failures++; $display("FAIL mid_four got=%h/%h exp=10/5a", acq1, slot(dq1, 4)); end
        rden[4] = 1'b0;
        tick; tick; tick;
        checks++; if (acq1 !== 8'h80 || slot(dq1, 7) !== 8'h6B) begin failures++; $display("FAIL mid_seven got=%h/%h exp=80/6b", acq1, slot(dq1, 7)); end
        rden[7] = 1'b0;
        tick;
    endtask

    task automatic test_rd_lat2;
        do_reset;
        set_req(3, 8'h70, 8'h00);
        rden[3] = 1'b1;
        tick; tick; tick;
        checks++; if (acq2 !== 8'h00 || busy2 !== 1'b1) begin failures++; $display("FAIL lat2_early got=%h/%b exp=00/1", acq2, busy2); end
        tick;
        checks++; if (acq2 !== 8'h08 || slot(dq2, 3) !== 8'hE7) begin failures++; $display("FAIL lat2_acq got=%h/%h exp=08/e7", acq2, slot(dq2, 3)); end
        rden[3] = 1'b0;
        tick;
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL lat2_idle got=%b exp=0", busy2); end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_single_write;
        test_read_write_both;
        test_contention;
        test_starvation;
        test_reset_mid_access;
        test_rd_lat2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Round-robin arbiter that shares one single-port synchronous RAM (IRAM or DRAM, registered address, RD_LAT read latency) between NREQ cores.
- Sits between the core array and the RAM macro.
- Each core raises a read or write request and holds it until its one-cycle acq pulse.
- One RAM access is in flight at a time. Each requester gets a private registered read-data slot.

Parameters:
- NREQ, 8, number of requesters (power of two, 2..16).
- AW, 8, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, RAM clock-to-q read latency in cycles (1..3).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rden  in  NREQ  per-requester read request (level).
- wren  in  NREQ  per-requester write request (level).
- Address  in  NREQ*AW  concatenated addresses; requester i is at [i*AW +: AW].
- Din  in  NREQ*DW  concatenated write data, same indexing.
- acq  out  NREQ  one-hot completion pulse, one cycle long.
- Dq  out  NREQ*DW  per-requester last read data, registered.
- RAMAddress  out  AW  RAM address.
- RAMDin  out  DW  RAM write data.
- RAMwren  out  1  RAM write enable.
- RAMq  in  DW  RAM read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; grant = 0; rr pointer = 0; acq = 0; Dq = 0; RAMwren = 0; RAMAddress = 0; RAMDin = 0; busy = 0. Asserting reset mid-access abandons the access: no acq, no write after reset.
- Request: req[i] = rden[i] | wren[i]. If both bits are set, the access is one write. Requesters hold Address and Din stable until acq.
- Arbitration: round-robin starting at the rr pointer, searching upward with wrap from NREQ-1 to 0. After a grant, rr pointer = grant+1 mod NREQ.
- FSM:
  - IDLE: if any req, latch grant index, address, data and is_write into registers, then go to ACCESS.
  - ACCESS (1 cycle): drive RAMAddress and RAMDin from the latched registers. RAMwren = is_write, registered, so it is high only during ACCESS. Next state is DONE for a write, WAIT for a read.
  - WAIT (RD_LAT cycles, reads only): counter counts down. On the final WAIT edge, capture RAMq into Dq slot [grant], then go to DONE.
  - DONE (1 cycle): acq[grant] = 1. Arbitrate with req[grant] masked. If another request is pending, latch it and go straight to ACCESS; otherwise go to IDLE.
- Latency, counted from the edge that samples the request in IDLE:
  - Write: RAM write at edge +2; acq high during cycle +2.
  - Read: Dq valid and acq high during cycle 2+RD_LAT.
  - Back-to-back service adds no IDLE bubble.
- Dq slots other than the grantee's never change. Writes never alter Dq.
- If a requester drops its request after being latched, the access still completes and acq still pulses.
- A requester that keeps its request asserted past acq is treated as a new request. Because of the rr pointer it is served after every other pending requester.
- Address, Din, rden and wren of non-granted requesters are ignored.
- RAMAddress and RAMDin hold their last value outside ACCESS. RAMwren is 0 outside ACCESS.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3;
  - a log2 helper function for index widths.
- One sub-module, rr_pick:
  - inputs: NREQ-bit req, mask and rr pointer;
  - outputs: valid plus winner index, combinational.

Test Plan:
- Single read: RD_LAT=1, RAM[0x10]=0xA5, rden[3]=1, Address3=0x10 → RAMAddress=0x10 in cycle +1; acq=8'b0000_1000 and Dq3=0xA5 in cycle +3; all other Dq unchanged.
- Single write: wren[5]=1, Address5=0x22, Din5=0x3C → RAMwren=1 only in cycle +1 with RAMAddress=0x22 and RAMDin=0x3C; acq[5] in cycle +2; a later read of 0x22 by requester 0 returns 0x3C.
- Contention: all 8 requesters reading from reset (pointer 0), each held until its acq → acq order 0,1,…,7; one acq every 3 cycles; busy high throughout; no IDLE cycles.
- Starvation: requester 2 holds rden permanently and requester 6 requests once → requester 6 is served immediately after 2's current access; 2 is never granted twice in a row while 6 is pending.
- rden[1] and wren[1] both high → exactly one write, Dq1 unchanged, single acq pulse.
- Reset mid-access: assert rst low during WAIT → acq=0, RAMwren=0 and Dq all zero immediately; after release, a pending request restarts arbitration from pointer 0.
- RD_LAT=2 build: a single read gives acq at cycle +4 with the correct data.
